// File: rtl/hamming_dec_arbiter.sv
// Round-robin arbiter that shares one registered Hamming(7,4) decoder among NUM_REQ requesters,
// returning each result tagged with its requester index and keeping saturating decode statistics.
module hamming_dec_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DEC_LAT = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                 clk_dec,
   input  logic                 rst_dec,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [7*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [6:0]           dec_data_o,
   input  logic [2:0]           dec_err_i,
   input  logic [3:0]           dec_out_i,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [2:0]           resp_id,
   output logic [3:0]           resp_data,
   output logic [2:0]           resp_syn,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     cnt_total,
   output logic [CNT_W-1:0]     cnt_err
);

   localparam int unsigned PTR_W  = $clog2(NUM_REQ);
   localparam int unsigned WCNT_W = $clog2(DEC_LAT + 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
   logic [6:0]         dec_data_nxt;
   logic               resp_valid_nxt;
   logic [2:0]         resp_id_nxt;
   logic [3:0]         resp_data_nxt;
   logic [2:0]         resp_syn_nxt;
   logic [CNT_W-1:0]   cnt_total_nxt, cnt_err_nxt;
   logic               done;
   logic               gnt_found;
   logic [PTR_W-1:0]   gnt_idx;
   int unsigned        idx;
   logic [6:0]         cw [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_cw
      assign cw[i] = req_data[7*i +: 7];
   end

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_found && req_valid[PTR_W'(idx)]) begin
            gnt_found = 1'b1;
            gnt_idx   = PTR_W'(idx);
         end
      end
   end

   // Next-state and datapath update for the accept / wait / respond sequence
   always_comb begin
      state_nxt      = state;
      rr_ptr_nxt     = rr_ptr;
      wcnt_nxt       = wcnt;
      dec_data_nxt   = dec_data_o;
      resp_valid_nxt = resp_valid;
      resp_id_nxt    = resp_id;
      resp_data_nxt  = resp_data;
      resp_syn_nxt   = resp_syn;
      req_ready      = '0;
      done           = 1'b0;
      case (state)
         S_IDLE: begin
            if (gnt_found && rst_dec) begin
               req_ready[gnt_idx] = 1'b1;
               dec_data_nxt       = cw[gnt_idx];
               resp_id_nxt        = 3'(gnt_idx);
               rr_ptr_nxt         = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
               wcnt_nxt           = '0;
               state_nxt          = S_WAIT;
            end
         end
         S_WAIT: begin
            wcnt_nxt = wcnt + WCNT_W'(1);
            if (wcnt == WCNT_W'(DEC_LAT)) begin
               resp_data_nxt  = dec_out_i;
               resp_syn_nxt   = dec_err_i;
               resp_valid_nxt = 1'b1;
               done           = 1'b1;
               state_nxt      = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_nxt = 1'b0;
               state_nxt      = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Saturating statistics; clear wins over a same-edge completion
   always_comb begin
      cnt_total_nxt = cnt_total;
      cnt_err_nxt   = cnt_err;
      if (cnt_clr) begin
         cnt_total_nxt = '0;
         cnt_err_nxt   = '0;
      end else if (done) begin
         if (cnt_total != '1) cnt_total_nxt = cnt_total + CNT_W'(1);
         if ((dec_err_i != 3'd0) && (cnt_err != '1)) cnt_err_nxt = cnt_err + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_dec) begin
      if (!rst_dec) begin
         state      <= S_IDLE;
         rr_ptr     <= '0;
         wcnt       <= '0;
         dec_data_o <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_data  <= '0;
         resp_syn   <= '0;
         cnt_total  <= '0;
         cnt_err    <= '0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_nxt;
         wcnt       <= wcnt_nxt;
         dec_data_o <= dec_data_nxt;
         resp_valid <= resp_valid_nxt;
         resp_id    <= resp_id_nxt;
         resp_data  <= resp_data_nxt;
         resp_syn   <= resp_syn_nxt;
         cnt_total  <= cnt_total_nxt;
         cnt_err    <= cnt_err_nxt;
      end
   end

   a_ready_onehot: assert property (@(posedge clk_dec) disable iff (!rst_dec) $onehot0(req_ready));
   a_ready_idle:   assert property (@(posedge clk_dec) disable iff (!rst_dec)
                                    (state != S_IDLE) |-> (req_ready == '0));

endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// Bench for hamming_dec_arbiter: stub registered decoder, nearest-codeword reference model,
// round-robin/counter model, plus a 4-bit-counter instance for saturation.
`timescale 1ns/1ps
module tb_hamming_dec_arbiter;
   localparam int NREQ  = 4;
   localparam int DL    = 1;
   localparam int MAX16 = 65535;
   localparam int MAX4  = 15;

   logic        clk_dec = 1'b0;
   logic        rst_dec;
   logic [3:0]  req_valid;
   logic [27:0] req_data;
   logic        resp_ready, cnt_clr;
   logic [3:0]  req_ready, req_ready_s;
   logic [6:0]  dec_data_o, dec_data_s;
   logic [2:0]  dec_err_i;
   logic [3:0]  dec_out_i;
   logic        resp_valid, resp_valid_s;
   logic [2:0]  resp_id, resp_id_s, resp_syn, resp_syn_s;
   logic [3:0]  resp_data, resp_data_s;
   logic [15:0] cnt_total, cnt_err;
   logic [3:0]  cnt_total_s, cnt_err_s;

   logic        force_en;
   logic [2:0]  force_syn;
   logic [3:0]  force_data;
   logic [6:0]  stub_q [DL];

   int n_cmp = 0, n_bad = 0;
   int m_ptr, m_total, m_err, ms_total, ms_err;

   always #5 clk_dec = ~clk_dec;

   hamming_dec_arbiter #(.NUM_REQ(NREQ), .DEC_LAT(DL), .CNT_W(16)) dut (
      .clk_dec(clk_dec), .rst_dec(rst_dec), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .dec_data_o(dec_data_o), .dec_err_i(dec_err_i), .dec_out_i(dec_out_i),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
      .resp_syn(resp_syn), .cnt_clr(cnt_clr), .cnt_total(cnt_total), .cnt_err(cnt_err));

   hamming_dec_arbiter #(.NUM_REQ(NREQ), .DEC_LAT(DL), .CNT_W(4)) dut_s (
      .clk_dec(clk_dec), .rst_dec(rst_dec), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready_s), .dec_data_o(dec_data_s), .dec_err_i(dec_err_i), .dec_out_i(dec_out_i),
      .resp_valid(resp_valid_s), .resp_ready(resp_ready), .resp_id(resp_id_s), .resp_data(resp_data_s),
      .resp_syn(resp_syn_s), .cnt_clr(cnt_clr), .cnt_total(cnt_total_s), .cnt_err(cnt_err_s));

   // Stub decoder: parity-check syndrome and single-bit correction, or forced outputs
   function automatic logic [6:0] stub_dec(input logic [6:0] c);
      logic [2:0] s;
      logic [6:0] f;
      s = 3'd0;
      for (int p = 1; p <= 7; p++) if (c[3'(7 - p)]) s = s ^ 3'(p);
      f = c;
      if (s != 3'd0) f = c ^ (7'd1 << (3'd7 - s));
      return {s, f[4], f[2], f[1], f[0]};
   endfunction

   always @(posedge clk_dec) begin
      stub_q[0] <= force_en ? {force_syn, force_data} : stub_dec(dec_data_o);
      for (int i = 1; i < DL; i++) stub_q[i] <= stub_q[i-1];
   end
   assign {dec_err_i, dec_out_i} = stub_q[DL-1];

   function automatic logic [6:0] enc(input logic [3:0] d);
      return {d[3]^d[2]^d[0], d[3]^d[1]^d[0], d[3], d[2]^d[1]^d[0], d[2], d[1], d[0]};
   endfunction

   // Reference: nearest codeword by exhaustive search; syndrome = flipped position
   function automatic logic [6:0] ref_dec(input logic [6:0] c);
      logic [6:0] diff;
      for (int d = 0; d < 16; d++) begin
         diff = enc(4'(d)) ^ c;
         if (diff == 7'd0) return {3'd0, 4'(d)};
         for (int b = 0; b < 7; b++) if (diff == (7'd1 << b)) return {3'(7 - b), 4'(d)};
      end
      return 7'd0;
   endfunction

   function automatic int exp_grant(input logic [3:0] v, input int p);
      for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return 0;
   endfunction

   task automatic cycle();
      @(posedge clk_dec);
      #1;
   endtask

   task automatic model_reset();
      m_ptr = 0; m_total = 0; m_err = 0; ms_total = 0; ms_err = 0;
   endtask

   task automatic apply_reset();
      rst_dec = 1'b0; req_valid = '0; cnt_clr = 1'b0;
      cycle(); cycle();
      rst_dec = 1'b1;
      model_reset();
   endtask

   // One full transaction from IDLE; returns the observed req_ready strobe
   task automatic do_decode(input logic [3:0] mask, input int hold, input bit clr, output logic [3:0] obs);
      logic [6:0] cw, exp;
      int g, k;
      req_valid  = mask;
      resp_ready = (hold == 0);
      #1;
      obs = req_ready;
      g   = exp_grant(mask, m_ptr);
      n_cmp++; if (req_ready !== 4'(1 << g)) begin n_bad++; $display("FAIL grant: got %b want %b", req_ready, 4'(1 << g)); end
      n_cmp++; if (req_ready_s !== 4'(1 << g)) begin n_bad++; $display("FAIL grant_s: got %b want %b", req_ready_s, 4'(1 << g)); end
      cw    = req_data[7*g +: 7];
      exp   = force_en ? {force_syn, force_data} : ref_dec(cw);
      m_ptr = (g + 1) % NREQ;
      cycle();
      n_cmp++; if (dec_data_o !== cw) begin n_bad++; $display("FAIL dec_data: got %b want %b", dec_data_o, cw); end
      n_cmp++; if (dec_data_s !== cw) begin n_bad++; $display("FAIL dec_data_s: got %b want %b", dec_data_s, cw); end
      n_cmp++; if (req_ready !== 4'd0 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL wait_state: got ready %b valid %b want 0 0", req_ready, resp_valid); end
      k = 0;
      while (resp_valid !== 1'b1 && k < 10) begin
         if (clr && k == DL) cnt_clr = 1'b1;
         cycle();
         cnt_clr = 1'b0;
         k++;
      end
      n_cmp++; if (k != DL + 1) begin n_bad++; $display("FAIL latency: got %0d want %0d", k, DL + 1); end
      if (clr) begin
         m_total = 0; m_err = 0; ms_total = 0; ms_err = 0;
      end else begin
         if (m_total < MAX16) m_total++;
         if (ms_total < MAX4) ms_total++;
         if (exp[6:4] != 3'd0 && m_err < MAX16) m_err++;
         if (exp[6:4] != 3'd0 && ms_err < MAX4) ms_err++;
      end
      n_cmp++; if ({resp_id, resp_syn, resp_data} !== {3'(g), exp}) begin n_bad++; $display("FAIL resp: got id %0d syn %0d data %h want id %0d syn %0d data %h", resp_id, resp_syn, resp_data, g, exp[6:4], exp[3:0]); end
      n_cmp++; if ({resp_valid_s, resp_id_s, resp_syn_s, resp_data_s} !== {1'b1, 3'(g), exp}) begin n_bad++; $display("FAIL resp_s: got v %b id %0d syn %0d data %h", resp_valid_s, resp_id_s, resp_syn_s, resp_data_s); end
      n_cmp++; if (cnt_total !== 16'(m_total) || cnt_err !== 16'(m_err)) begin n_bad++; $display("FAIL counters: got %0d/%0d want %0d/%0d", cnt_total, cnt_err, m_total, m_err); end
      n_cmp++; if (cnt_total_s !== 4'(ms_total) || cnt_err_s !== 4'(ms_err)) begin n_bad++; $display("FAIL counters_s: got %0d/%0d want %0d/%0d", cnt_total_s, cnt_err_s, ms_total, ms_err); end
      for (int h = 0; h < hold; h++) begin
         cycle();
         n_cmp++; if ({resp_valid, resp_id, resp_syn, resp_data, req_ready} !== {1'b1, 3'(g), exp, 4'd0}) begin n_bad++; $display("FAIL hold: got v %b id %0d syn %0d data %h rdy %b", resp_valid, resp_id, resp_syn, resp_data, req_ready); end
      end
      resp_ready = 1'b1;
      cycle();
      n_cmp++; if (resp_valid !== 1'b0 || resp_valid_s !== 1'b0) begin n_bad++; $display("FAIL release: got %b %b want 0 0", resp_valid, resp_valid_s); end
   endtask

   task automatic test_reset();
      rst_dec = 1'b0; req_valid = 4'hF; req_data = '0; resp_ready = 1'b0; cnt_clr = 1'b0;
      force_en = 1'b0; force_syn = '0; force_data = '0;
      repeat (3) cycle();
      n_cmp++; if (req_ready !== 4'd0 || req_ready_s !== 4'd0) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
      n_cmp++; if (resp_valid !== 1'b0 || cnt_total !== 16'd0 || cnt_err !== 16'd0) begin n_bad++; $display("FAIL rst_out: got v %b tot %0d err %0d want 0", resp_valid, cnt_total, cnt_err); end
      n_cmp++; if ({dec_data_o, resp_id, resp_data, resp_syn} !== 17'd0) begin n_bad++; $display("FAIL rst_regs: got %h want 0", {dec_data_o, resp_id, resp_data, resp_syn}); end
      rst_dec = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_first_grant: got %b want 0001", req_ready); end
      req_valid = '0;
      model_reset();
   endtask

   task automatic test_single();
      logic [3:0] obs;
      force_en = 1'b1; force_syn = 3'd0; force_data = 4'hA;
      req_data = '0; req_data[20:14] = 7'b1010101;
      do_decode(4'b0100, 0, 1'b0, obs);
      n_cmp++; if (obs !== 4'b0100 || cnt_total !== 16'd1 || cnt_err !== 16'd0) begin n_bad++; $display("FAIL single: got rdy %b cnt %0d/%0d want 0100 1/0", obs, cnt_total, cnt_err); end
      force_en = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [3:0] obs;
      int order [5] = '{0, 1, 2, 3, 0};
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         req_data = 28'($urandom);
         do_decode(4'hF, 0, 1'b0, obs);
         n_cmp++; if (obs !== 4'(1 << order[i])) begin n_bad++; $display("FAIL rr_order%0d: got %b want %b", i, obs, 4'(1 << order[i])); end
         if (i == 3) begin
            n_cmp++; if (cnt_total !== 16'd4) begin n_bad++; $display("FAIL rr_total: got %0d want 4", cnt_total); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] obs;
      req_data = 28'($urandom);
      do_decode(4'($urandom_range(1, 15)), 5, 1'b0, obs);
      req_data = 28'($urandom);
      do_decode(4'hF, 0, 1'b0, obs);
   endtask

   task automatic test_err_clear();
      logic [3:0] obs;
      apply_reset();
      force_en = 1'b1; force_syn = 3'b101;
      for (int i = 0; i < 3; i++) begin
         force_data = 4'($urandom);
         do_decode(4'hF, 0, 1'b0, obs);
      end
      n_cmp++; if (cnt_err !== 16'd3 || cnt_total !== 16'd3) begin n_bad++; $display("FAIL err_count: got %0d/%0d want 3/3", cnt_total, cnt_err); end
      do_decode(4'hF, 0, 1'b1, obs);
      n_cmp++; if (cnt_err !== 16'd0 || cnt_total !== 16'd0) begin n_bad++; $display("FAIL clr_priority: got %0d/%0d want 0/0", cnt_total, cnt_err); end
      force_en = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      logic [3:0] obs;
      req_data = 28'($urandom);
      req_valid = 4'b0100; resp_ready = 1'b1;
      #1;
      cycle();
      rst_dec = 1'b0; req_valid = '0;
      cycle();
      rst_dec = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         cycle();
         n_cmp++; if (resp_valid !== 1'b0 || cnt_total !== 16'd0 || cnt_err !== 16'd0) begin n_bad++; $display("FAIL mid_wait_rst: got v %b cnt %0d/%0d want 0", resp_valid, cnt_total, cnt_err); end
      end
      req_data = 28'($urandom);
      do_decode(4'hF, 0, 1'b0, obs);
      n_cmp++; if (obs !== 4'b0001) begin n_bad++; $display("FAIL post_rst_grant: got %b want 0001", obs); end
   endtask

   task automatic test_saturation();
      logic [3:0] obs;
      apply_reset();
      force_en = 1'b1; force_syn = 3'b101;
      for (int i = 0; i < 17; i++) begin
         force_data = 4'($urandom);
         req_data = 28'($urandom);
         do_decode(4'hF, 0, 1'b0, obs);
      end
      n_cmp++; if (cnt_total_s !== 4'd15 || cnt_err_s !== 4'd15) begin n_bad++; $display("FAIL saturate: got %0d/%0d want 15/15", cnt_total_s, cnt_err_s); end
      n_cmp++; if (cnt_total !== 16'd17 || cnt_err !== 16'd17) begin n_bad++; $display("FAIL no_saturate: got %0d/%0d want 17/17", cnt_total, cnt_err); end
      force_en = 1'b0;
   endtask

   task automatic test_random();
      logic [3:0] obs;
      for (int i = 0; i < 40; i++) begin
         force_en   = 1'($urandom_range(0, 1));
         force_syn  = 3'($urandom);
         force_data = 4'($urandom);
         req_data   = 28'($urandom);
         do_decode(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 1'b0, obs);
      end
      force_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_err_clear();
      test_reset_mid_wait();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
